// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen, sprite-size and judge-state definitions
package game_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;

  localparam int B_W_DEF = 10;
  localparam int B_H_DEF = 20;
  localparam int E_W_DEF = 50;
  localparam int E_H_DEF = 40;

  localparam int HP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } judge_state_e;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational 11-bit axis-aligned box overlap test
module box_overlap
  import game_pkg::*;
#(
  parameter int A_W = B_W_DEF,
  parameter int A_H = B_H_DEF,
  parameter int B_W = E_W_DEF,
  parameter int B_H = E_H_DEF
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  output logic               overlap_o
);

  // One extra bit keeps right/bottom edges near 1023 from wrapping.
  logic [COORD_W:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x_i};
  assign ay = {1'b0, a_y_i};
  assign bx = {1'b0, b_x_i};
  assign by = {1'b0, b_y_i};

  assign overlap_o = (ax + (COORD_W+1)'(A_W) > bx) &&
                     (ax < bx + (COORD_W+1)'(B_W)) &&
                     (ay + (COORD_W+1)'(A_H) > by) &&
                     (ay < by + (COORD_W+1)'(B_H));

endmodule

// File: rtl/enemy_boom_judge.sv
// rtl/enemy_boom_judge.sv - per-frame player-bullet vs enemy collision, damage and score
module enemy_boom_judge
  import game_pkg::*;
#(
  parameter int          N_B       = 4,
  parameter int          N_E       = 4,
  parameter int          B_W       = B_W_DEF,
  parameter int          B_H       = B_H_DEF,
  parameter int          E_W       = E_W_DEF,
  parameter int          E_H       = E_H_DEF,
  parameter int          E_HP      = 3,
  parameter logic [15:0] SCORE_RST = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick_i,
  input  logic [COORD_W*N_B-1:0]  pb_x_i,
  input  logic [COORD_W*N_B-1:0]  pb_y_i,
  input  logic [N_B-1:0]          pb_en_i,
  input  logic [COORD_W*N_E-1:0]  en_x_i,
  input  logic [COORD_W*N_E-1:0]  en_y_i,
  input  logic [N_E-1:0]          en_alive_i,
  input  logic [N_E-1:0]          en_spawn_i,
  output logic [N_B-1:0]          pb_clr_o,
  output logic [N_E-1:0]          en_kill_o,
  output logic [HP_W*N_E-1:0]     en_hp_o,
  output logic [15:0]             score_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);

  localparam int BI_W = (N_B > 1) ? $clog2(N_B) : 1;
  localparam int EI_W = (N_E > 1) ? $clog2(N_E) : 1;

  judge_state_e state_q, state_d;

  logic [BI_W-1:0]          b_q;
  logic [EI_W-1:0]          e_q;
  logic [COORD_W*N_B-1:0]   pbx_q, pby_q;
  logic [N_B-1:0]           pben_q;
  logic [COORD_W*N_E-1:0]   enx_q, eny_q;
  logic [N_E-1:0]           alive_q;
  logic [HP_W-1:0]          hp_q [N_E];
  logic [N_B-1:0]           consumed_q;
  logic [N_E-1:0]           kill_q;
  logic [N_E-1:0]           pend_q;
  logic [15:0]              score_q;
  logic                     overrun_q;

  logic                     last_b, last_e;
  logic                     ovl, hit;
  logic [HP_W-1:0]          cur_hp;
  logic [15:0]              kill_cnt;
  logic [16:0]              score_sum;
  logic [15:0]              score_nxt;

  assign last_b = (b_q == BI_W'(N_B-1));
  assign last_e = (e_q == EI_W'(N_E-1));
  assign cur_hp = hp_q[e_q];

  box_overlap #(
    .A_W(B_W), .A_H(B_H), .B_W(E_W), .B_H(E_H)
  ) u_overlap (
    .a_x_i    (pbx_q[COORD_W*b_q +: COORD_W]),
    .a_y_i    (pby_q[COORD_W*b_q +: COORD_W]),
    .b_x_i    (enx_q[COORD_W*e_q +: COORD_W]),
    .b_y_i    (eny_q[COORD_W*e_q +: COORD_W]),
    .overlap_o(ovl)
  );

  // Enemy index is outer, so a bullet is always claimed by the lowest enemy first.
  assign hit = (state_q == SCAN) && pben_q[b_q] && !consumed_q[b_q] &&
               alive_q[e_q] && (cur_hp != '0) && ovl;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < N_E; i++) begin
      kill_cnt = kill_cnt + 16'(kill_q[i]);
    end
    score_sum = {1'b0, score_q} + {1'b0, kill_cnt};
    score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick_i) state_d = SCAN;
      SCAN:    if (last_b && last_e) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      e_q        <= '0;
      pbx_q      <= '0;
      pby_q      <= '0;
      pben_q     <= '0;
      enx_q      <= '0;
      eny_q      <= '0;
      alive_q    <= '0;
      consumed_q <= '0;
      kill_q     <= '0;
      pend_q     <= '0;
      score_q    <= SCORE_RST;
      overrun_q  <= 1'b0;
      for (int i = 0; i < N_E; i++) hp_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      overrun_q <= frame_tick_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          for (int i = 0; i < N_E; i++) begin
            if (en_spawn_i[i]) hp_q[i] <= HP_W'(E_HP);
          end
          if (frame_tick_i) begin
            pbx_q      <= pb_x_i;
            pby_q      <= pb_y_i;
            pben_q     <= pb_en_i;
            enx_q      <= en_x_i;
            eny_q      <= en_y_i;
            alive_q    <= en_alive_i;
            consumed_q <= '0;
            kill_q     <= '0;
            b_q        <= '0;
            e_q        <= '0;
          end
        end
        SCAN: begin
          pend_q <= pend_q | en_spawn_i;
          if (hit) begin
            consumed_q[b_q] <= 1'b1;
            hp_q[e_q]       <= cur_hp - 1'b1;
            if (cur_hp == HP_W'(1)) kill_q[e_q] <= 1'b1;
          end
          if (last_b) begin
            b_q <= '0;
            if (!last_e) e_q <= e_q + 1'b1;
          end else begin
            b_q <= b_q + 1'b1;
          end
        end
        COMMIT: begin
          score_q <= score_nxt;
          pend_q  <= '0;
          // Deferred spawns land here so the first IDLE cycle already shows them.
          for (int i = 0; i < N_E; i++) begin
            if (pend_q[i] || en_spawn_i[i]) hp_q[i] <= HP_W'(E_HP);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_E; g++) begin : g_hp
    assign en_hp_o[HP_W*g +: HP_W] = hp_q[g];
  end

  assign pb_clr_o  = (state_q == COMMIT) ? consumed_q : '0;
  assign en_kill_o = (state_q == COMMIT) ? kill_q : '0;
  assign done_o    = (state_q == COMMIT);
  assign busy_o    = (state_q != IDLE);
  assign score_o   = score_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_enemy_boom_judge.sv
// tb/tb_enemy_boom_judge.sv - directed vector and corner-case bench for enemy_boom_judge
module tb_enemy_boom_judge;

  typedef struct {
    logic [3:0]  spawn;
    logic [39:0] pbx;
    logic [39:0] pby;
    logic [3:0]  pben;
    logic [39:0] enx;
    logic [39:0] eny;
    logic [3:0]  alive;
    logic [3:0]  clr;
    logic [3:0]  kill;
    logic [15:0] hp;
    logic [15:0] score;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rst2, frame_tick;
  logic [39:0] pb_x, pb_y, en_x, en_y;
  logic [3:0]  pb_en, en_alive, en_spawn;
  logic [3:0]  pb_clr, en_kill, d2_pb_clr, d2_en_kill;
  logic [15:0] en_hp, score, d2_en_hp, d2_score;
  logic        busy, done, overrun, d2_busy, d2_done, d2_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enemy_boom_judge dut (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick),
    .pb_x_i(pb_x), .pb_y_i(pb_y), .pb_en_i(pb_en),
    .en_x_i(en_x), .en_y_i(en_y), .en_alive_i(en_alive), .en_spawn_i(en_spawn),
    .pb_clr_o(pb_clr), .en_kill_o(en_kill), .en_hp_o(en_hp), .score_o(score),
    .busy_o(busy), .done_o(done), .overrun_o(overrun)
  );

  enemy_boom_judge #(.E_HP(1), .SCORE_RST(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst2), .frame_tick_i(frame_tick),
    .pb_x_i(pb_x), .pb_y_i(pb_y), .pb_en_i(pb_en),
    .en_x_i(en_x), .en_y_i(en_y), .en_alive_i(en_alive), .en_spawn_i(en_spawn),
    .pb_clr_o(d2_pb_clr), .en_kill_o(d2_en_kill), .en_hp_o(d2_en_hp), .score_o(d2_score),
    .busy_o(d2_busy), .done_o(d2_done), .overrun_o(d2_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] p4(input int s0, input int s1, input int s2, input int s3);
    return {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] sp, input logic [39:0] bx, input logic [39:0] by,
                              input logic [3:0] ben, input logic [39:0] ex, input logic [39:0] ey,
                              input logic [3:0] al, input logic [3:0] clr, input logic [3:0] kill,
                              input logic [15:0] hp, input logic [15:0] sc);
    vec_t v;
    v.spawn = sp; v.pbx = bx; v.pby = by; v.pben = ben;
    v.enx = ex; v.eny = ey; v.alive = al;
    v.clr = clr; v.kill = kill; v.hp = hp; v.score = sc;
    return v;
  endfunction

  // Pulse frame_tick and count cycles from the tick until done (bounded).
  task automatic run_tick(output int n);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      step();
      n++;
    end
  endtask

  vec_t        vecs [12];
  logic [39:0] ex_d, ey_d, ex_m, ey_m, b_e0, y110;
  int          n, bad;

  initial begin
    rst = 1'b1; rst2 = 1'b1; frame_tick = 1'b0;
    pb_x = '0; pb_y = '0; pb_en = '0;
    en_x = '0; en_y = '0; en_alive = '0; en_spawn = '0;

    ex_d = p4(100, 300, 100, 400);
    ey_d = p4(100, 100, 300, 300);
    ex_m = p4(100, 300, 100, 130);
    ey_m = p4(100, 100, 300, 100);
    b_e0 = p4(120, 0, 0, 0);
    y110 = p4(110, 0, 0, 0);

    vecs[0]  = mk(4'hF, '0, '0, 4'b0000, ex_d, ey_d, 4'hF, 4'b0000, 4'b0000, 16'h3333, 16'd0);
    vecs[1]  = mk(4'h0, p4(0, 0, 120, 0), p4(0, 0, 110, 0), 4'b0100, ex_d, ey_d, 4'hF, 4'b0100, 4'b0000, 16'h3332, 16'd0);
    vecs[2]  = mk(4'h0, p4(0, 0, 120, 0), p4(0, 0, 110, 0), 4'b0100, ex_d, ey_d, 4'hF, 4'b0100, 4'b0000, 16'h3331, 16'd0);
    vecs[3]  = mk(4'h0, p4(0, 0, 120, 0), p4(0, 0, 110, 0), 4'b0100, ex_d, ey_d, 4'hF, 4'b0100, 4'b0001, 16'h3330, 16'd1);
    vecs[4]  = mk(4'h1, p4(90, 91, 0, 0), p4(100, 100, 0, 0), 4'b0011, ex_d, ey_d, 4'hF, 4'b0010, 4'b0000, 16'h3332, 16'd1);
    vecs[5]  = mk(4'h0, p4(310, 0, 0, 0), y110, 4'b0001, ex_d, ey_d, 4'hF, 4'b0001, 4'b0000, 16'h3322, 16'd1);
    vecs[6]  = mk(4'h0, p4(310, 0, 0, 0), y110, 4'b0001, ex_d, ey_d, 4'hF, 4'b0001, 4'b0000, 16'h3312, 16'd1);
    vecs[7]  = mk(4'h0, p4(310, 320, 0, 0), p4(110, 120, 0, 0), 4'b0011, ex_d, ey_d, 4'hF, 4'b0001, 4'b0010, 16'h3302, 16'd2);
    vecs[8]  = mk(4'h0, p4(135, 0, 0, 0), y110, 4'b0001, ex_m, ey_m, 4'hF, 4'b0001, 4'b0000, 16'h3301, 16'd2);
    vecs[9]  = mk(4'h0, p4(120, 150, 0, 0), p4(80, 110, 0, 0), 4'b0011, ex_d, ey_d, 4'hF, 4'b0000, 4'b0000, 16'h3301, 16'd2);
    vecs[10] = mk(4'h0, b_e0, y110, 4'b0001, ex_d, ey_d, 4'hE, 4'b0000, 4'b0000, 16'h3301, 16'd2);
    vecs[11] = mk(4'h0, b_e0, y110, 4'b0001, ex_d, ey_d, 4'hF, 4'b0001, 4'b0001, 16'h3300, 16'd3);

    step(); step();
    rst = 1'b0;
    step();
    chk("reset en_hp", en_hp, 16'h0000);
    chk("reset score", score, 16'h0000);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset pb_clr", pb_clr, 4'b0000);
    chk("reset en_kill", en_kill, 4'b0000);
    chk("reset overrun", overrun, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].spawn != 4'h0) begin
        en_spawn = vecs[i].spawn;
        step();
        en_spawn = '0;
      end
      pb_x = vecs[i].pbx; pb_y = vecs[i].pby; pb_en = vecs[i].pben;
      en_x = vecs[i].enx; en_y = vecs[i].eny; en_alive = vecs[i].alive;
      run_tick(n);
      chk($sformatf("v%0d latency", i), n, 17);
      chk($sformatf("v%0d pb_clr", i), pb_clr, vecs[i].clr);
      chk($sformatf("v%0d en_kill", i), en_kill, vecs[i].kill);
      step();
      chk($sformatf("v%0d en_hp", i), en_hp, vecs[i].hp);
      chk($sformatf("v%0d score", i), score, vecs[i].score);
      chk($sformatf("v%0d busy after", i), busy, 1'b0);
    end

    // Overrun and a spawn deferred across SCAN/COMMIT.
    pb_en = '0; en_x = ex_d; en_y = ey_d; en_alive = 4'hF;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("ovr busy c1", busy, 1'b1);
    step(); step();
    en_spawn = 4'b0001;
    step();
    en_spawn = '0;
    step();
    frame_tick = 1'b1;
    chk("ovr overrun c5", overrun, 1'b0);
    step();
    frame_tick = 1'b0;
    chk("ovr overrun c6", overrun, 1'b1);
    step();
    chk("ovr overrun c7", overrun, 1'b0);
    n = 7;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("ovr latency", n, 17);
    chk("ovr hp0 at commit", en_hp[3:0], 4'h0);
    step();
    chk("ovr hp after commit", en_hp, 16'h3303);
    chk("ovr busy after", busy, 1'b0);

    // Mid-scan reset, with an early hit visible during SCAN.
    pb_x = b_e0; pb_y = y110; pb_en = 4'b0001;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("rst hp mid-scan", en_hp[3:0], 4'h2);
    for (int c = 2; c < 8; c++) step();
    rst = 1'b1;
    #1;
    chk("rst en_hp", en_hp, 16'h0000);
    chk("rst busy", busy, 1'b0);
    chk("rst score", score, 16'h0000);
    bad = 0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done || pb_clr != 4'b0 || en_kill != 4'b0) bad++;
      step();
    end
    chk("rst no pulses", bad, 0);
    chk("rst idle", busy, 1'b0);

    // Spawn coinciding with frame_tick: scan sees the fresh health.
    en_spawn = 4'b0001;
    frame_tick = 1'b1;
    step();
    en_spawn = '0;
    frame_tick = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("spawn+tick latency", n, 17);
    chk("spawn+tick pb_clr", pb_clr, 4'b0001);
    chk("spawn+tick en_kill", en_kill, 4'b0000);
    step();
    chk("spawn+tick en_hp", en_hp, 16'h0002);

    // Score saturation: two kills from 16'hFFFE in one frame.
    rst2 = 1'b0;
    step();
    en_spawn = 4'hF;
    step();
    en_spawn = '0;
    pb_x = p4(120, 310, 0, 0); pb_y = p4(110, 110, 0, 0); pb_en = 4'b0011;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 1;
    while (!d2_done && n < 40) begin
      step();
      n++;
    end
    chk("sat latency", n, 17);
    chk("sat en_kill", d2_en_kill, 4'b0011);
    step();
    chk("sat score", d2_score, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_boom_judge.md
# enemy_boom_judge

Collision and damage judge for the player's bullets against enemy ships. It is the counterpart of the player-side hit judge, which handles enemy bullets against the player. Once per video frame it snapshots all player-bullet and enemy positions and scans every bullet/enemy pair sequentially. It then decrements enemy health, retires consumed bullets, reports kills and maintains the score. It sits between the player-bullet manager, the enemy manager and the score/HUD logic.

## Interface
Parameters:
- N_B, 4: number of player-bullet slots.
- N_E, 4: number of enemy slots.
- B_W, 10 / B_H, 20: bullet bounding-box width and height, in pixels.
- E_W, 50 / E_H, 40: enemy bounding-box width and height, in pixels.
- E_HP, 3: health loaded on spawn. Range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse at frame start; begins a scan.
- pb_x, pb_y  in  10*N_B each  packed bullet top-left coordinates. Slot i is bits [10i+9:10i].
- pb_en  in  N_B  bullet slot active.
- en_x, en_y  in  10*N_E each  packed enemy top-left coordinates.
- en_alive  in  N_E  enemy slot present on screen.
- en_spawn  in  N_E  one-cycle pulse per slot; reloads that enemy's health.
- pb_clr  out  N_B  one-cycle pulse per slot; the bullet was consumed.
- en_kill  out  N_E  one-cycle pulse per slot; the enemy's health reached 0.
- en_hp  out  4*N_E  current health per enemy.
- score  out  16  number of kills, saturating.
- busy  out  1  high from snapshot through commit.
- done  out  1  one-cycle pulse when a scan commits.
- overrun  out  1  one-cycle pulse when a frame_tick arrives while busy.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- IDLE to SCAN on frame_tick.
  - In that same edge, register all position buses, pb_en and en_alive into snapshot registers.
  - Clear the consumed-bullet mask and the kill mask.
  - Set the pair indices e=0, b=0.
- SCAN evaluates one pair (e,b) per cycle.
  - Index order: b is the inner index, e is the outer index.
  - A hit requires all of the following: snap_en[b], consumed[b]==0, snap_alive[e], hp[e]!=0, and box overlap.
  - Box overlap requires all four: bx+B_W > ex, bx < ex+E_W, by+B_H > ey, by < ey+E_H.
  - All sums are computed at 11 bits, so there is no wrap at 1023.
- On a hit:
  - Set consumed[b].
  - Set hp[e] to hp[e]-1.
  - If the new hp is 0, set kill[e].
- Each bullet damages at most one enemy per frame. The lowest enemy index wins.
- Subsequent bullets are not tested against an enemy whose hp is 0.
- SCAN to COMMIT after pair (N_E-1, N_B-1).
- COMMIT, for one cycle:
  - pb_clr = consumed.
  - en_kill = kill.
  - score += popcount(kill), saturating at 16'hFFFF.
  - done = 1.
- COMMIT to IDLE.
- Spawn handling:
  - An en_spawn pulse in IDLE sets hp[e]=E_HP at the next edge.
  - An en_spawn pulse during SCAN or COMMIT is latched in a pending vector and applied on the first IDLE cycle after COMMIT.
  - A spawn pulse for a slot that is already alive still reloads that slot's health.
- frame_tick in IDLE coinciding with en_spawn: the spawn wins. The health is reloaded before the scan reads it, so the scan uses E_HP.
- frame_tick while busy: ignored, and overrun pulses for one cycle.

## Timing
- Reset values:
  - State IDLE.
  - All en_hp = 0 (dead until spawned).
  - score = 0.
  - pb_clr, en_kill, done, overrun = 0.
  - busy = 0.
  - Pending spawns, consumed mask and kill mask cleared.
- Reset mid-scan aborts the scan with no pulses issued and no score change.
- Latency: frame_tick at cycle T gives done, pb_clr and en_kill at cycle T+1+N_E*N_B. With defaults this is T+17.
- busy is high for cycles T+1 through T+1+N_E*N_B inclusive.
- en_hp updates are visible the cycle after each hit, during SCAN.
- Input buses are don't-care after the snapshot edge.

## Structure
- Package game_pkg holds:
  - Screen constants H_RES=640 and V_RES=480.
  - Default box sizes.
  - HP width (4).
  - The judge state enum {IDLE, SCAN, COMMIT}.
- Sub-module box_overlap: a purely combinational 11-bit AABB overlap test, parameterised by the two box sizes. It is shared with the player-side judge.
- Top level contains the FSM, the index counters, the snapshot registers, the hp array, the masks and the score.

## Test plan
- Reset, spawn all enemies, frame_tick with no bullets → done at T+17; all en_hp=3; pb_clr=0; en_kill=0; score=0.
- Enemy 0 at (100,100), bullet 2 at (120,110) active → in COMMIT, pb_clr=4'b0100 and en_hp[0]=2. Over three frames: kill on the third, en_kill=4'b0001, score=1.
- Edge adjacency: bullet at (90,100) gives bx+B_W=100, no hit. Bullet at (91,100) gives a hit.
- Bullets 0 and 1 both overlap enemy 1 with hp=1 → bullet 0 kills it and pb_clr=4'b0001. Bullet 1 is not consumed.
- One bullet overlapping enemies 0 and 3 → only enemy 0 is damaged.
- Second frame_tick at T+5 → overrun pulse at T+6; the scan is unaffected. en_spawn during SCAN → hp reloaded on the cycle after COMMIT.
- Preload score to 16'hFFFE and kill two enemies in one frame → score=16'hFFFF.
- Assert rst at T+8 → no done and no pulses; state IDLE; hp=0.
